// File: rtl/ula_pkg.sv
// ula_pkg: opcode encodings, FSM state type and opcode helper for ula_multiciclo
package ula_pkg;
  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_OR    = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_PASSA = 5'd3;
  localparam logic [4:0] OP_SEQ   = 5'd4;
  localparam logic [4:0] OP_SNE   = 5'd5;
  localparam logic [4:0] OP_SUB   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_LUI   = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd9;
  localparam logic [4:0] OP_SRL   = 5'd10;
  localparam logic [4:0] OP_NOR   = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12;
  localparam logic [4:0] OP_SLTU  = 5'd13;
  localparam logic [4:0] OP_XOR   = 5'd14;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MFHI  = 5'd20;
  localparam logic [4:0] OP_MFLO  = 5'd21;
  typedef enum logic {IDLE, CALC} state_t;
  function automatic logic is_iter(input logic [4:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/ula_muldiv.sv
// ula_muldiv: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes with sign fix-up.
//   clock        in  rising-edge clock
//   load         in  capture operand magnitudes and op kind
//   step         in  perform one iteration
//   op           in  MULT/MULTU/DIV/DIVU select (sampled on load)
//   a, b         in  operands (sampled on load)
//   hi_n, lo_n   out result after the current step, sign-corrected (valid on the final step)
module ula_muldiv import ula_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clock,
  input  logic             load,
  input  logic             step,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic [WIDTH-1:0] r, q, m, r_n, q_n, abs_a, abs_b, diff;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] prod;
  logic sgn, dv, div_q, neg_q, neg_r, ge;
  always_comb begin
    sgn = op == OP_MULT || op == OP_DIV;
    dv = op == OP_DIV || op == OP_DIVU;
    abs_a = (sgn && a[WIDTH-1]) ? -a : a;
    abs_b = (sgn && b[WIDTH-1]) ? -b : b;
    sum = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
    t = {r, q[WIDTH-1]};
    ge = t >= {1'b0, m};
    diff = t[WIDTH-1:0] - m;
    r_n = div_q ? (ge ? diff : t[WIDTH-1:0]) : sum[WIDTH:1];
    q_n = div_q ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
    prod = neg_q ? -{r_n, q_n} : {r_n, q_n};
    hi_n = div_q ? (neg_r ? -r_n : r_n) : prod[2*WIDTH-1:WIDTH];
    lo_n = div_q ? (neg_q ? -q_n : q_n) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clock) begin
    if (load) begin
      r <= '0;
      q <= abs_a;
      m <= abs_b;
      div_q <= dv;
      neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn && dv && a[WIDTH-1];
    end else if (step) begin
      r <= r_n;
      q <= q_n;
    end
  end
endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multicycle ALU with single-cycle ops and iterative MULT/DIV into HI/LO.
//   clock, reset   in  rising-edge clock, synchronous active-high reset
//   start, op      in  operation request (taken only when idle) and opcode
//   a, b, SHAMT    in  operands and shift amount
//   S, Z           out registered result and zero flag
//   ovf, div_zero  out signed ADD/SUB overflow, divisor-was-zero
//   busy, done     out iterative op running, one-cycle completion pulse
//   hi, lo         out HI/LO registers
module ula_multiciclo import ula_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   SHAMT,
  output logic [WIDTH-1:0] S,
  output logic             Z,
  output logic             ovf,
  output logic             div_zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_n;
  logic [SHW-1:0] cnt;
  logic [WIDTH-1:0] res, sum, dif, hi_n, lo_n;
  logic accept, iter, dz, last, res_ovf;
  assign busy = state == CALC;
  always_comb begin
    accept = start && state == IDLE;
    iter = is_iter(op);
    dz = (op == OP_DIV || op == OP_DIVU) && b == '0;
    last = busy && cnt == SHW'(WIDTH - 1);
    state_n = (accept && iter && !dz) ? CALC : last ? IDLE : state;
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    sum = a + b;
    dif = a - b;
    res = '0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_ADD:   res = sum;
      OP_PASSA: res = a;
      OP_SEQ:   res = {{(WIDTH-1){1'b0}}, a == b};
      OP_SNE:   res = {{(WIDTH-1){1'b0}}, a != b};
      OP_SUB:   res = dif;
      OP_SLT:   res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_LUI:   res = b << (WIDTH / 2);
      OP_SLL:   res = a << SHAMT;
      OP_SRL:   res = a >> SHAMT;
      OP_NOR:   res = ~(a | b);
      OP_SRA:   res = $signed(a) >>> SHAMT;
      OP_SLTU:  res = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:   res = a ^ b;
      OP_MFHI:  res = hi;
      OP_MFLO:  res = lo;
      default:  res = '0;
    endcase
    // overflow when both inputs agree in sign (for SUB: differ) and the result sign flips
    res_ovf = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
              op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1]) : 1'b0;
  end
  ula_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock (clock),
    .load  (accept && iter && !dz),
    .step  (busy),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_n  (hi_n),
    .lo_n  (lo_n)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      S <= '0;
      Z <= 1'b1;
      ovf <= 1'b0;
      div_zero <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        done <= !iter || dz;
        ovf <= res_ovf;
        div_zero <= dz;
        cnt <= '0;
        if (!iter) begin
          S <= res;
          Z <= res == '0;
        end
      end
      if (busy) begin
        cnt <= cnt + 1'b1;
        if (last) begin
          done <= 1'b1;
          hi <= hi_n;
          lo <= lo_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: randomized and directed checks of ula_multiciclo against an arithmetic reference model
module tb_ula_multiciclo;
  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;
  logic clock = 1'b0, reset, start;
  logic [4:0] op, SHAMT;
  logic [W-1:0] a, b, S, hi, lo;
  logic Z, ovf, div_zero, busy, done;
  logic [W-1:0] m_s, m_hi, m_lo;
  logic m_z, m_ovf, m_dz;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  ula_multiciclo #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .SHAMT(SHAMT),
    .S(S), .Z(Z), .ovf(ovf), .div_zero(div_zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, "_S"}, S, m_s);
    check({tag, "_Z"}, Z, m_z);
    check({tag, "_ovf"}, ovf, m_ovf);
    check({tag, "_dz"}, div_zero, m_dz);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask
  task automatic model_reset;
    m_s = '0; m_z = 1'b1; m_ovf = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
  endtask
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [4:0] sh, input bit poke);
    bit it, zd;
    int n, bc;
    longint p, q, r;
    logic [63:0] u;
    it = o inside {5'd16, 5'd17, 5'd18, 5'd19};
    zd = (o == 5'd18 || o == 5'd19) && y == 0;
    m_ovf = 1'b0;
    m_dz = zd;
    if (!it) begin
      p = 0;
      case (o)
        5'd0:  p = x & y;
        5'd1:  p = x | y;
        5'd2:  begin p = longint'($signed(x)) + longint'($signed(y)); m_ovf = p > MAXS || p < MINS; end
        5'd3:  p = x;
        5'd4:  p = (x == y) ? 1 : 0;
        5'd5:  p = (x != y) ? 1 : 0;
        5'd6:  begin p = longint'($signed(x)) - longint'($signed(y)); m_ovf = p > MAXS || p < MINS; end
        5'd7:  p = ($signed(x) < $signed(y)) ? 1 : 0;
        5'd8:  p = longint'(y) * 65536;
        5'd9:  p = longint'(x) * (longint'(1) << sh);
        5'd10: p = longint'(x) / (longint'(1) << sh);
        5'd11: p = ~(x | y);
        5'd12: p = longint'($signed(x)) >>> sh;
        5'd13: p = (x < y) ? 1 : 0;
        5'd14: p = x ^ y;
        5'd20: p = m_hi;
        5'd21: p = m_lo;
        default: p = 0;
      endcase
      m_s = p[31:0];
      m_z = m_s == 0;
    end else if (!zd) begin
      case (o)
        5'd16: begin u = longint'($signed(x)) * longint'($signed(y)); m_hi = u[63:32]; m_lo = u[31:0]; end
        5'd17: begin u = {32'd0, x} * {32'd0, y}; m_hi = u[63:32]; m_lo = u[31:0]; end
        5'd18: begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        default: begin m_lo = x / y; m_hi = x % y; end
      endcase
    end
    start = 1'b1; op = o; a = x; b = y; SHAMT = sh;
    tick;
    start = 1'b0; a = $urandom; b = $urandom; SHAMT = 5'($urandom);
    n = 1;
    bc = 0;
    while (done !== 1'b1 && n < 100) begin
      bc += (busy === 1'b1) ? 1 : 0;
      if (poke && n == 5) begin start = 1'b1; op = 5'd2; a = 1; b = 1; end
      if (n == 6) start = 1'b0;
      tick;
      n++;
    end
    check("latency", n, (it && !zd) ? W + 1 : 1);
    check("busy_cycles", bc, (it && !zd) ? W : 0);
    check_all($sformatf("op%0d", o));
  endtask
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; SHAMT = '0;
    model_reset();
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_all("rst");
    reset = 1'b0;
    run_op(5'd2, 32'h7FFFFFFF, 32'd1, 5'd0, 0);
    check("add_ovf_k", {S, ovf}, {32'h80000000, 1'b1});
    run_op(5'd16, -32'sd3, 32'd5, 5'd0, 1);
    check("mult_k", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    check("add_ignored_S", S, 32'h80000000);
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 0);
    check("mfhi_k", S, 32'hFFFFFFFF);
    run_op(5'd17, -32'sd3, 32'd5, 5'd0, 0);
    check("multu_k", {hi, lo}, 64'h00000004_FFFFFFF1);
    run_op(5'd21, 32'd0, 32'd0, 5'd0, 0);
    run_op(5'd18, -32'sd7, 32'd2, 5'd0, 0);
    check("div_k", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(5'd19, 32'd7, 32'd0, 5'd0, 0);
    check("divu_zero_k", {div_zero, hi, lo}, {1'b1, 64'hFFFFFFFF_FFFFFFFD});
    run_op(5'd18, 32'h80000000, 32'hFFFFFFFF, 5'd0, 0);
    check("div_minneg_k", {hi, lo}, 64'h00000000_80000000);
    run_op(5'd12, 32'h80000000, 32'd0, 5'd4, 0);
    check("sra_k", S, 32'hF8000000);
    run_op(5'd6, 32'd5, 32'd5, 5'd0, 0);
    check("sub_k", {S, Z, ovf}, {32'd0, 1'b1, 1'b0});
    run_op(5'd17, 32'd123456, 32'd654321, 5'd0, 0);
    start = 1'b1; op = 5'd16; a = 32'd3; b = 32'd5;
    tick;
    start = 1'b0;
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_reset();
    check("abort_busy", busy, 0);
    check_all("abort");
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      dn += (done === 1'b1) ? 1 : 0;
      tick;
    end
    check("abort_no_done", dn, 0);
    check("abort_hilo", {hi, lo}, 64'd0);
    run_op(5'd2, 32'd10, 32'd20, 5'd0, 0);
    reset = 1'b1; start = 1'b1; op = 5'd16; a = 32'd7; b = 32'd9;
    tick;
    reset = 1'b0; start = 1'b0;
    model_reset();
    check("rst_pri_done", done, 0);
    check_all("rst_pri");
    tick;
    check("rst_pri_busy", busy, 0);
    check("rst_pri_done2", done, 0);
    for (int i = 0; i < 150; i++)
      run_op(5'($urandom_range(0, 23)), pick(), pick(), 5'($urandom), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8..64, powers of 2.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have clock  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have start  in  1  operation request, sampled only while busy=0.
REQ-006 SHALL have op  in  5  operation select, encoding per ula_pkg.
REQ-007 SHALL have a, b  in  WIDTH  operands; SHAMT  in  SHW  shift amount.
REQ-008 SHALL have S  out  WIDTH  registered result; Z  out  1  registered (S==0).
REQ-009 SHALL have ovf  out  1  signed overflow of ADD/SUB; div_zero  out  1  divisor was zero.
REQ-010 SHALL have busy  out  1  iterative op in progress; done  out  1  one-cycle completion pulse.
REQ-011 SHALL have hi, lo  out  WIDTH  registered HI/LO.

Function
REQ-012 Opcodes: 0 AND, 1 OR, 2 ADD, 3 PASS A, 4 SEQ, 5 SNE, 6 SUB, 7 SLT, 8 LUI (b<<WIDTH/2), 9 SLL, 10 SRL, 11 NOR, 12 SRA, 13 SLTU, 14 XOR, 16 MULT, 17 MULTU, 18 DIV, 19 DIVU, 20 MFHI, 21 MFLO; any other: S=0.
REQ-013 Single-cycle ops (0-14, 20, 21, undefined): S, Z, ovf updated at edge sampling start; done=1 next cycle; busy stays 0.
REQ-014 SEQ/SNE/SLT/SLTU SHALL write S=1 or 0; SLT signed, SLTU unsigned.
REQ-015 Shifts SHALL shift a by SHAMT; SRA sign-fills; SLL/SRL zero-fill.
REQ-016 ovf SHALL be 1 only for ADD/SUB signed overflow; cleared by every other accepted op.
REQ-017 Iterative ops (16-19) SHALL leave S and Z unchanged; FSM IDLE -> CALC (WIDTH cycles, busy=1) -> IDLE.
REQ-018 done SHALL pulse exactly WIDTH+1 cycles after the start cycle; hi/lo SHALL hold new values from that cycle.
REQ-019 MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed/unsigned respectively.
REQ-020 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-021 DIV of most-negative by -1: lo = most-negative, hi = 0, no error flag.
REQ-022 Divisor zero (DIV/DIVU): no CALC; div_zero=1, done next cycle, hi/lo unchanged; div_zero cleared by next accepted op.
REQ-023 start while busy=1 SHALL be ignored, with no effect on any output.
REQ-024 start with done=1 in the same cycle SHALL be accepted normally (back-to-back).
REQ-025 Operands SHALL be captured at acceptance; a/b changes during CALC have no effect.
REQ-026 MFHI/MFLO issued immediately after done SHALL return the new hi/lo.

Reset
REQ-027 reset SHALL force S=0, Z=1, ovf=0, div_zero=0, busy=0, done=0, hi=lo=0, FSM=IDLE.
REQ-028 reset during CALC SHALL abort: no done pulse, hi/lo=0.
REQ-029 reset SHALL take priority over start in the same cycle.

Structure
REQ-030 Package ula_pkg SHALL hold opcode localparams and FSM state encoding (IDLE, CALC).
REQ-031 Iterative datapath SHALL be sub-module ula_muldiv (shift-add multiplier, restoring divider, sign fix-up), parametrised by WIDTH.
REQ-032 Top SHALL hold the single-cycle datapath, FSM, iteration counter and output registers.

Verification (WIDTH=32)
REQ-033 ADD a=0x7FFFFFFF, b=1 -> S=0x80000000, ovf=1, Z=0, done 1 cycle after start, busy never high.
REQ-034 MULT a=-3, b=5 -> busy 32 cycles, done at start+33, hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-035 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> div_zero=1, done next cycle, hi/lo unchanged.
REQ-036 ADD start asserted during MULT CALC -> ignored, S unchanged; reset at cycle 10 of MULT -> busy=0, no done, hi=lo=0.
REQ-037 SRA a=0x80000000, SHAMT=4 -> S=0xF8000000; SUB a=5, b=5 -> S=0, Z=1, ovf=0.
